// File: rtl/hex_pkg.sv
// hex_pkg
//   Shared constants and types for the binary-to-display-digit converter.
//   Holds the digit count, operand width, the largest value that still fits
//   in six decimal digits, the 4-bit display codes understood by the
//   downstream 7-segment decoder, and the converter state enum.
package hex_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int VALUE_W    = 20;
  localparam int DIGITS_W   = NUM_DIGITS * 4;

  localparam logic [VALUE_W-1:0] MAX_VALUE = 20'd999999;

  // Double-dabble needs one shift per operand bit.
  localparam logic [4:0] SHIFT_CYCLES = 5'd20;

  localparam logic [3:0] CODE_UNDERSCORE = 4'hC;
  localparam logic [3:0] CODE_L          = 4'hD;
  localparam logic [3:0] CODE_E          = 4'hE;
  localparam logic [3:0] CODE_BLANK      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_add3.sv
// bcd_add3
//   Combinational double-dabble correction cell for one BCD nibble: any
//   nibble of 5 or more gets 3 added so that the following left shift
//   carries correctly into the next decimal digit.
//   Ports:
//     nibble_i  4-bit BCD digit before correction
//     nibble_o  4-bit BCD digit after correction
module bcd_add3 (
  input  logic [3:0] nibble_i,
  output logic [3:0] nibble_o
);

  assign nibble_o = (nibble_i >= 4'd5) ? (nibble_i + 4'd3) : nibble_i;

endmodule

// File: rtl/bin_to_digits.sv
// bin_to_digits
//   Converts a 20-bit unsigned value into six 4-bit display codes using a
//   sequential double-dabble (one operand bit per cycle). Results are
//   published together with a one-cycle done pulse, a fixed 22 cycles after
//   the accepted start edge. Values above 999999 show "_____E" and raise
//   overflow. Optional leading-zero blanking replaces leading zero digits
//   (never digit0) with the blank code.
//   Ports:
//     clk       rising-edge clock
//     rst_n     asynchronous active-low reset
//     start     conversion request, only honoured while idle
//     value     20-bit operand, captured with start
//     lz_blank  leading-zero blanking enable, captured with start
//     busy      high while a conversion is in progress
//     done      one-cycle pulse when digits/overflow update
//     digits    six display codes, digit0 at [3:0], digit5 at [23:20]
//     overflow  last converted value exceeded 999999
module bin_to_digits
  import hex_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [VALUE_W-1:0]  value,
  input  logic                lz_blank,
  output logic                busy,
  output logic                done,
  output logic [DIGITS_W-1:0] digits,
  output logic                overflow
);

  state_e                state_q;
  logic [4:0]            shiftCnt_q;
  logic [VALUE_W-1:0]    operand_q;
  logic [DIGITS_W-1:0]   bcd_q;
  logic                  lzBlank_q;
  logic                  ovf_q;

  logic [DIGITS_W-1:0]   bcdAdj;
  logic [DIGITS_W-1:0]   bcdShift_d;
  logic [DIGITS_W-1:0]   display_d;
  logic                  leadZero;

  // One correction cell per BCD digit; all six are corrected in parallel
  // before each shift.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_add3
    bcd_add3 u_add3 (
      .nibble_i (bcd_q[g*4 +: 4]),
      .nibble_o (bcdAdj[g*4 +: 4])
    );
  end

  // The next operand MSB enters at the bottom of the BCD register. For
  // overflowing operands the top bits fall off, which is harmless because
  // that result is replaced by the overflow pattern anyway.
  assign bcdShift_d = {bcdAdj[DIGITS_W-2:0], operand_q[VALUE_W-1]};

  // Final formatting of the finished BCD value. Blanking walks down from
  // digit5 and stops at the first nonzero digit; digit0 is never examined
  // so a value of zero still shows a single '0'.
  always_comb begin
    display_d = bcd_q;
    leadZero  = 1'b1;
    if (ovf_q) begin
      display_d = {{(NUM_DIGITS-1){CODE_UNDERSCORE}}, CODE_E};
    end else if (lzBlank_q) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        if (leadZero && (bcd_q[i*4 +: 4] == 4'd0)) begin
          display_d[i*4 +: 4] = CODE_BLANK;
        end else begin
          leadZero = 1'b0;
        end
      end
    end
  end

  // Control FSM with registered outputs. SHIFT spends 20 edges shifting and
  // one more edge handing over to BLANK; BLANK publishes the formatted
  // result. That gives the fixed 22-cycle latency whether or not the value
  // overflows. Outputs only change on the done edge, so partial results are
  // never visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shiftCnt_q <= '0;
      operand_q  <= '0;
      bcd_q      <= '0;
      lzBlank_q  <= 1'b0;
      ovf_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      digits     <= {NUM_DIGITS{CODE_BLANK}};
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            operand_q  <= value;
            lzBlank_q  <= lz_blank;
            ovf_q      <= (value > MAX_VALUE);
            bcd_q      <= '0;
            shiftCnt_q <= '0;
            busy       <= 1'b1;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (shiftCnt_q == SHIFT_CYCLES) begin
            state_q <= ST_BLANK;
          end else begin
            bcd_q      <= bcdShift_d;
            operand_q  <= {operand_q[VALUE_W-2:0], 1'b0};
            shiftCnt_q <= shiftCnt_q + 5'd1;
          end
        end
        ST_BLANK: begin
          digits   <= display_d;
          overflow <= ovf_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_digits.sv
// tb_bin_to_digits
//   Self-checking bench for bin_to_digits: directed vector table, random
//   operands against a decimal reference model, and hand-written sequences
//   for start-while-busy, back-to-back start and mid-conversion reset.
module tb_bin_to_digits;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] value = '0;
  logic        lz_blank = 1'b0;
  logic        busy;
  logic        done;
  logic [23:0] digits;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  bin_to_digits dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .value    (value),
    .lz_blank (lz_blank),
    .busy     (busy),
    .done     (done),
    .digits   (digits),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [19:0] v;
    bit          lz;
    logic [23:0] expDigits;
    bit          expOvf;
  } vec_t;

  // Reference: decimal digits by repeated division, then blank every zero
  // above the highest nonzero digit (never digit0).
  function automatic logic [23:0] refDigits(input int unsigned v, input bit lz);
    logic [23:0] r;
    int unsigned rem;
    int d[6];
    int top;
    if (v > 999999) return 24'hCCCCCE;
    rem = v;
    for (int i = 0; i < 6; i++) begin
      d[i] = int'(rem % 10);
      rem  = rem / 10;
    end
    top = 0;
    for (int i = 0; i < 6; i++) if (d[i] != 0) top = i;
    r = '0;
    for (int i = 0; i < 6; i++) r[i*4 +: 4] = (lz && i > top) ? 4'hF : 4'(d[i]);
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one start request and waits for done; lat is the number of
  // edges from the start edge to the edge that raised done (0 = timeout).
  task automatic applyStimulus(input logic [19:0] v, input bit lz, input bit immediate,
                               output int lat, output bit heldOk);
    logic [23:0] prevDigits;
    logic        prevOvf;
    if (!immediate) @(negedge clk);
    start    = 1'b1;
    value    = v;
    lz_blank = lz;
    prevDigits = digits;
    prevOvf    = overflow;
    @(posedge clk);
    #1;
    start  = 1'b0;
    lat    = 0;
    heldOk = 1'b1;
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
      if (digits !== prevDigits || overflow !== prevOvf) heldOk = 1'b0;
    end
  endtask

  task automatic runAndCheck(input string name, input logic [19:0] v, input bit lz, input bit immediate);
    int lat;
    bit heldOk;
    applyStimulus(v, lz, immediate, lat, heldOk);
    checkOutput({name, ".latency"}, 32'(lat), 32'd22);
    checkOutput({name, ".digits"}, 32'(digits), 32'(refDigits(int'(v), lz)));
    checkOutput({name, ".overflow"}, 32'(overflow), 32'(int'(v) > 999999));
    checkOutput({name, ".held"}, 32'(heldOk), 32'd1);
    checkOutput({name, ".busyAtDone"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   lat;
    bit   heldOk;
    bit   sawDone;
    int   doneCount;
    logic [19:0] rv;
    bit   rlz;

    vecs.push_back('{"v123456",  20'd123456,  1'b1, 24'h123456, 1'b0});
    vecs.push_back('{"v42blank", 20'd42,      1'b1, 24'hFFFF42, 1'b0});
    vecs.push_back('{"v42zeros", 20'd42,      1'b0, 24'h000042, 1'b0});
    vecs.push_back('{"v0blank",  20'd0,       1'b1, 24'hFFFFF0, 1'b0});
    vecs.push_back('{"v0zeros",  20'd0,       1'b0, 24'h000000, 1'b0});
    vecs.push_back('{"v999999",  20'd999999,  1'b1, 24'h999999, 1'b0});
    vecs.push_back('{"v1000000", 20'd1000000, 1'b1, 24'hCCCCCE, 1'b1});
    vecs.push_back('{"vFFFFF",   20'hFFFFF,   1'b0, 24'hCCCCCE, 1'b1});
    vecs.push_back('{"v100000",  20'd100000,  1'b1, 24'h100000, 1'b0});
    vecs.push_back('{"v1005",    20'd1005,    1'b1, 24'hFF1005, 1'b0});

    // Reset state
    #12;
    checkOutput("reset.busy", 32'(busy), 32'd0);
    checkOutput("reset.done", 32'(done), 32'd0);
    checkOutput("reset.overflow", 32'(overflow), 32'd0);
    checkOutput("reset.digits", 32'(digits), 32'hFFFFFF);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].lz, 1'b0, lat, heldOk);
      checkOutput({vecs[i].name, ".latency"}, 32'(lat), 32'd22);
      checkOutput({vecs[i].name, ".digits"}, 32'(digits), 32'(vecs[i].expDigits));
      checkOutput({vecs[i].name, ".overflow"}, 32'(overflow), 32'(vecs[i].expOvf));
      checkOutput({vecs[i].name, ".held"}, 32'(heldOk), 32'd1);
    end

    // Random operands against the reference model
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 2))
        0:       rv = 20'($urandom_range(0, 999));
        1:       rv = 20'($urandom_range(0, 999999));
        default: rv = 20'($urandom_range(0, 20'hFFFFF));
      endcase
      rlz = 1'($urandom_range(0, 1));
      runAndCheck("random", rv, rlz, 1'b0);
    end

    // Start pulsed five cycles into a conversion must be ignored
    @(negedge clk);
    start = 1'b1; value = 20'd654321; lz_blank = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; value = 20'd7; lz_blank = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    for (int c = 6; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    checkOutput("busyIgnore.latency", 32'(lat), 32'd22);
    checkOutput("busyIgnore.digits", 32'(digits), 32'h654321);
    doneCount = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("busyIgnore.extraDone", 32'(doneCount), 32'd0);

    // Start raised in the done cycle is accepted at the next edge
    runAndCheck("b2bFirst", 20'd31415, 1'b1, 1'b0);
    runAndCheck("b2bSecond", 20'd27182, 1'b0, 1'b1);

    // Reset in the middle of shifting abandons the conversion
    @(negedge clk);
    start = 1'b1; value = 20'd55555; lz_blank = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midReset.busy", 32'(busy), 32'd0);
    checkOutput("midReset.digits", 32'(digits), 32'hFFFFFF);
    checkOutput("midReset.overflow", 32'(overflow), 32'd0);
    checkOutput("midReset.done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) sawDone = 1'b1;
    end
    checkOutput("midReset.noDone", 32'(sawDone), 32'd0);
    runAndCheck("afterReset", 20'd8080, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
